// File: rtl/selector_74153_pkg.sv
// Shared helpers for the dual 4:1 selector.
// Bit selection is an index, so unselected X/Z data bits never reach the output.
package selector_74153_pkg;

    function automatic logic sel4(input logic [3:0] d, input logic [1:0] s);
        return d[s];
    endfunction

endpackage

// File: rtl/selector_74153_mux4_gated.sv
// One 74x153 section: 4:1 mux followed by an active-low enable gate.
module selector_74153_mux4_gated
    import selector_74153_pkg::*;
(
    input  logic [3:0] d_i,
    input  logic [1:0] s_i,
    input  logic       en_ni,
    output logic       y_o
);

    // Gate after the mux so a disabled section is a clean 0 even with X select/data.
    always_comb begin
        y_o = ~en_ni & sel4(d_i, s_i);
    end

endmodule

// File: rtl/selector_74153.sv
// Dual 4-to-1 data selector (74x153) with an optional registered output stage.
module selector_74153
    import selector_74153_pkg::*;
#(
    parameter bit REGISTERED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i1,
    input  logic [3:0] i2,
    input  logic [1:0] s,
    input  logic       e1,
    input  logic       e2,
    output logic       y1,
    output logic       y2
);

    logic y1_d, y2_d;

    selector_74153_mux4_gated u_sec1 (
        .d_i  (i1),
        .s_i  (s),
        .en_ni(e1),
        .y_o  (y1_d)
    );

    selector_74153_mux4_gated u_sec2 (
        .d_i  (i2),
        .s_i  (s),
        .en_ni(e2),
        .y_o  (y2_d)
    );

    if (REGISTERED) begin : g_reg
        logic y1_q, y2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                y1_q <= 1'b0;
                y2_q <= 1'b0;
            end else begin
                y1_q <= y1_d;
                y2_q <= y2_d;
            end
        end

        assign y1 = y1_q;
        assign y2 = y2_q;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign y1 = y1_d;
        assign y2 = y2_d;
    end

endmodule

// File: tb/tb_selector_74153.sv
// Directed bench for selector_74153: combinational build and registered build side by side.
`timescale 1ns / 1ps
module tb_selector_74153;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [3:0] i1, i2;
    logic [1:0] s;
    logic       e1, e2;
    logic       y1, y2;

    logic [3:0] r_i1, r_i2;
    logic [1:0] r_s;
    logic       r_e1, r_e2;
    logic       r_y1, r_y2;

    int passed = 0;
    int total  = 0;

    always #500 clk = ~clk;

    selector_74153 #(.REGISTERED(1'b0)) u_comb (
        .clk(clk),
        .rst(rst),
        .i1 (i1),
        .i2 (i2),
        .s  (s),
        .e1 (e1),
        .e2 (e2),
        .y1 (y1),
        .y2 (y2)
    );

    selector_74153 #(.REGISTERED(1'b1)) u_reg (
        .clk(clk),
        .rst(rst),
        .i1 (r_i1),
        .i2 (r_i2),
        .s  (r_s),
        .e1 (r_e1),
        .e2 (r_e2),
        .y1 (r_y1),
        .y2 (r_y2)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        // Combinational build
        e1 = 1'b1; e2 = 1'b1; i1 = 4'bxxxx; i2 = 4'bxxxx; s = 2'bxx;
        #1000;
        check("dis_y1", y1, 1'b0);
        check("dis_y2", y2, 1'b0);

        // Section 1 walk: only the selected bit is driven
        e1 = 1'b0; e2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i1 = 4'bxxxx;
            s = k[2:1];
            i1[k[2:1]] = k[0];
            #1000;
            check($sformatf("walk1_s%0d_b%0d", k[2:1], k[0]), y1, k[0]);
        end

        // Section 2 walk with section 1 data all X
        e1 = 1'b0; e2 = 1'b0; i1 = 4'bxxxx;
        for (int k = 0; k < 8; k++) begin
            i2 = 4'bxxxx;
            s = k[2:1];
            i2[k[2:1]] = k[0];
            #1000;
            check($sformatf("walk2_s%0d_b%0d", k[2:1], k[0]), y2, k[0]);
        end

        // Independence of enables
        e1 = 1'b0; e2 = 1'b1; i1 = 4'b0100; i2 = 4'b1111; s = 2'b10;
        #1000;
        check("indep_y1", y1, 1'b1);
        check("indep_y2", y2, 1'b0);
        e1 = 1'b1;
        #1000;
        check("e1off_y1", y1, 1'b0);
        check("e1off_y2", y2, 1'b0);
        e2 = 1'b0;
        #1000;
        check("e2on_y2", y2, 1'b1);
        check("e2on_y1", y1, 1'b0);

        // Registered build
        @(negedge clk);
        rst = 1'b1; r_e1 = 1'b0; r_e2 = 1'b0; r_i1 = 4'b1111; r_i2 = 4'b1111; r_s = 2'b00;
        @(negedge clk);
        check("rst_y1", r_y1, 1'b0);
        check("rst_y2", r_y2, 1'b0);
        rst = 1'b0; r_i1 = 4'b1000; r_i2 = 4'b0111; r_s = 2'b11;
        #1;
        check("lat_y1", r_y1, 1'b0);
        @(negedge clk);
        check("cap_y1", r_y1, 1'b1);
        check("cap_y2", r_y2, 1'b0);
        r_s = 2'b01;
        #1;
        check("hold_y2", r_y2, 1'b0);
        @(negedge clk);
        check("cap2_y1", r_y1, 1'b0);
        check("cap2_y2", r_y2, 1'b1);
        r_s = 2'b11;
        @(negedge clk);
        check("cap3_y1", r_y1, 1'b1);
        rst = 1'b1;
        #1;
        check("prerst_y1", r_y1, 1'b1);
        @(negedge clk);
        check("midrst_y1", r_y1, 1'b0);
        check("midrst_y2", r_y2, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("resume_y1", r_y1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/selector_74153.md
Name: selector_74153

Overview:
- Dual 4-to-1 data selector, functionally equivalent to the 74x153 TTL part, used in the CPU model datapath.
- Two independent sections share one 2-bit select.
- Each section has its own active-low strobe (enable); a disabled section drives 0.
- Default build is purely combinational. An optional registered-output mode uses the block's single clock and synchronous reset.

Parameters:
- REGISTERED, 0, when 1 each output passes through a flip-flop (1-cycle latency); when 0 outputs are combinational and clk/rst are unused.

Ports:
- clk  input  1  single clock; used only when REGISTERED=1.
- rst  input  1  synchronous, active-high reset; used only when REGISTERED=1.
- i1  input  4  section-1 data inputs; bit n is selected when s==n.
- i2  input  4  section-2 data inputs; bit n is selected when s==n.
- s  input  2  common select for both sections.
- e1  input  1  section-1 enable, active low.
- e2  input  1  section-2 enable, active low.
- y1  output  1  section-1 output.
- y2  output  1  section-2 output.

Behaviour:
- Function: y1 = (~e1) AND i1[s]; y2 = (~e2) AND i2[s].
- s=00 selects bit 0, 01 bit 1, 10 bit 2, 11 bit 3. The same s value applies to both sections.
- Disabled section (e=1): its output is 0 regardless of s and data, including when s or data are X/Z in simulation.
  - Implement the enable as a gating AND applied after the mux, so a 0 from ~e forces a clean 0.
- Enabled section with a known s: the output equals the selected bit exactly.
  - X/Z on unselected data bits must never propagate to the output.
  - Use an index or case-style mux, not arithmetic or reduction over all bits.
- Sections are fully independent: e1 and i1 never affect y2, and vice versa.
- REGISTERED=0:
  - Zero-cycle latency; outputs follow inputs within the same delta.
  - No internal state; clk and rst are ignored.
- REGISTERED=1:
  - Each output is captured on the rising edge of clk; latency is 1 cycle.
  - When rst=1 at a rising edge, y1 and y2 become 0, overriding data.
  - Reset asserted mid-operation clears the outputs at the next edge. Normal capture resumes on the first edge with rst=0.
  - Outputs before the first edge or reset are undefined.
- Simultaneous changes of s, data and enable: REGISTERED=0 outputs settle to the function of the final values; REGISTERED=1 samples values at the clock edge.
- No timing delays inside the model; the bench applies stimulus with 1 us steps.

Decomposition:
- No shared package contents are required; no typedefs or constants are needed beyond the REGISTERED parameter.
- Natural sub-module: mux4_gated (one 4:1 section plus active-low enable gating), instantiated twice. The top level adds the optional output register stage.

Test Plan:
- e1=1, i1=xxxx, s=xx -> y1=0. Likewise e2=1, i2=xxxx, s=xx -> y2=0.
- e1=0, walk s=00..11, driving only the selected bit of i1 (0 then 1) and all other bits X -> y1 equals the driven bit each time (8 checks, no X on output).
- e2=0, i1=xxxx, walk s=00..11 with only the selected i2 bit driven 0/1 -> y2 equals the driven bit (8 checks). Confirms section independence.
- e1=0, e2=1, i1=4'b0100, i2=4'b1111, s=10 -> y1=1, y2=0. Then toggle e1 to 1 -> y1=0 with y2 unchanged.
- REGISTERED=1: rst=1 for one edge -> y1=y2=0. Then rst=0, e1=0, i1=4'b1000, s=11 -> y1 stays 0 until the next rising edge, then becomes 1. Reassert rst -> y1=0 at the following edge.
